// File: rtl/ldst_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ldst_queue_pkg
// Brief    : Shared opcodes, tag-width and ROB age-compare helpers for ldst_queue
// Revision : 1.0 - initial release
// ============================================================================
package ldst_queue_pkg;

    localparam logic [11:0] OPC_LW = 12'h003;
    localparam logic [11:0] OPC_SW = 12'h023;

    function automatic int tag_w(input int rob_bits);
        return rob_bits + 1;
    endfunction

    // Ages are distances from the ROB head, so wrap-around of tags is harmless.
    function automatic logic is_younger(input logic [31:0] tag,
                                        input logic [31:0] flush_tag,
                                        input logic [31:0] head,
                                        input int          rob_bits);
        logic [31:0] m;
        m = (32'd1 << rob_bits) - 32'd1;
        return ((tag - head) & m) > ((flush_tag - head) & m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ldst_cdb_snoop.sv
`default_nettype none
// ============================================================================
// Module   : ldst_cdb_snoop
// Brief    : Combinational match of one tag against all CDB ports
// Revision : 1.0 - initial release
// ============================================================================
module ldst_cdb_snoop
    import ldst_queue_pkg::*;
#(
    parameter int ROB_BITS = 4,
    parameter int N_CDB    = 4
) (
    input  logic [ROB_BITS:0]               i_tag,
    input  logic [N_CDB*(ROB_BITS+1)-1:0]   i_cdb_tag,
    input  logic [N_CDB*32-1:0]             i_cdb_val,
    output logic                            o_hit,
    output logic [31:0]                     o_val
);

    localparam int c_TAG_W = tag_w(ROB_BITS);

    // Scanning downward leaves the lowest-numbered matching port in place.
    always_comb begin
        o_hit = 1'b0;
        o_val = 32'd0;
        for (int k = N_CDB - 1; k >= 0; k--) begin
            if (i_tag != '0 && i_cdb_tag[k*c_TAG_W +: c_TAG_W] == i_tag) begin
                o_hit = 1'b1;
                o_val = i_cdb_val[k*32 +: 32];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ldst_queue.sv
`default_nettype none
// ============================================================================
// Module   : ldst_queue
// Brief    : In-order load/store queue with CDB snooping, EA calc and flush
// Revision : 1.0 - initial release
// ============================================================================
module ldst_queue
    import ldst_queue_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int ROB_BITS      = 4,
    parameter int N_CDB         = 4,
    parameter int MEM_BITS      = 12,
    parameter int STORE_AT_HEAD = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ROB_BITS:0]               in_rob_tag,
    input  logic [ROB_BITS:0]               in_tag1,
    input  logic [ROB_BITS:0]               in_tag2,
    input  logic [4:0]                      in_rd,
    input  logic [11:0]                     in_opcode,
    input  logic [31:0]                     in_val1,
    input  logic [31:0]                     in_val2,
    input  logic [31:0]                     in_imm,
    input  logic [ROB_BITS:0]               rob_head,
    input  logic                            flush_all,
    input  logic                            flush_younger,
    input  logic [ROB_BITS:0]               flush_tag,
    input  logic [N_CDB*(ROB_BITS+1)-1:0]   cdb_tag,
    input  logic [N_CDB*32-1:0]             cdb_val,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ROB_BITS:0]               out_rob_tag,
    output logic [4:0]                      out_rd,
    output logic [11:0]                     out_opcode,
    output logic [31:0]                     out_val1,
    output logic [31:0]                     out_val2,
    output logic [31:0]                     out_imm,
    output logic [31:0]                     out_ea,
    output logic [$clog2(DEPTH):0]          count,
    output logic [$clog2(DEPTH)-1:0]        head_idx,
    output logic [$clog2(DEPTH)-1:0]        tail_idx
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_IDX_W + 1;
    localparam int c_TAG_W = tag_w(ROB_BITS);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [31:0] c_EA_MASK = (MEM_BITS >= 32) ? 32'hFFFF_FFFF :
                                        32'((64'd1 << MEM_BITS) - 64'd1);

    function automatic logic [31:0] calc_ea(input logic [31:0] base, input logic [31:0] imm);
        return (base + imm) & c_EA_MASK;
    endfunction

    // Entry storage
    logic [DEPTH-1:0]   r_busy;
    logic [11:0]        r_opcode  [DEPTH];
    logic [4:0]         r_rd      [DEPTH];
    logic [c_TAG_W-1:0] r_rob_tag [DEPTH];
    logic [c_TAG_W-1:0] r_tag1    [DEPTH];
    logic [c_TAG_W-1:0] r_tag2    [DEPTH];
    logic [31:0]        r_val1    [DEPTH];
    logic [31:0]        r_val2    [DEPTH];
    logic [31:0]        r_imm     [DEPTH];
    logic [31:0]        r_ea      [DEPTH];

    logic [c_IDX_W-1:0] r_head;
    logic [c_IDX_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               r_out_valid;
    logic [c_TAG_W-1:0] r_out_rob_tag;
    logic [4:0]         r_out_rd;
    logic [11:0]        r_out_opcode;
    logic [31:0]        r_out_val1;
    logic [31:0]        r_out_val2;
    logic [31:0]        r_out_imm;
    logic [31:0]        r_out_ea;

    // Snoop results
    logic [DEPTH-1:0]         w_hit1;
    logic [DEPTH-1:0]         w_hit2;
    logic [DEPTH-1:0][31:0]   w_cval1;
    logic [DEPTH-1:0][31:0]   w_cval2;
    logic                     w_in_hit1;
    logic                     w_in_hit2;
    logic [31:0]              w_in_cval1;
    logic [31:0]              w_in_cval2;

    logic [31:0]        w_in_val1;
    logic [31:0]        w_in_val2;
    logic [c_TAG_W-1:0] w_in_tag1;
    logic [c_TAG_W-1:0] w_in_tag2;

    logic               w_enq;
    logic               w_head_rdy;
    logic               w_sw_block;
    logic               w_issue;

    logic [DEPTH-1:0]   w_young;
    logic [c_CNT_W-1:0] w_n_young;
    logic               w_any_young;
    logic [c_IDX_W-1:0] w_new_tail;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_out_young;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry_snoop
            ldst_cdb_snoop #(.ROB_BITS(ROB_BITS), .N_CDB(N_CDB)) u_snoop1 (
                .i_tag     (r_tag1[i]),
                .i_cdb_tag (cdb_tag),
                .i_cdb_val (cdb_val),
                .o_hit     (w_hit1[i]),
                .o_val     (w_cval1[i])
            );
            ldst_cdb_snoop #(.ROB_BITS(ROB_BITS), .N_CDB(N_CDB)) u_snoop2 (
                .i_tag     (r_tag2[i]),
                .i_cdb_tag (cdb_tag),
                .i_cdb_val (cdb_val),
                .o_hit     (w_hit2[i]),
                .o_val     (w_cval2[i])
            );
        end
    endgenerate

    ldst_cdb_snoop #(.ROB_BITS(ROB_BITS), .N_CDB(N_CDB)) u_in_snoop1 (
        .i_tag     (in_tag1),
        .i_cdb_tag (cdb_tag),
        .i_cdb_val (cdb_val),
        .o_hit     (w_in_hit1),
        .o_val     (w_in_cval1)
    );

    ldst_cdb_snoop #(.ROB_BITS(ROB_BITS), .N_CDB(N_CDB)) u_in_snoop2 (
        .i_tag     (in_tag2),
        .i_cdb_tag (cdb_tag),
        .i_cdb_val (cdb_val),
        .o_hit     (w_in_hit2),
        .o_val     (w_in_cval2)
    );

    assign w_in_val1 = w_in_hit1 ? w_in_cval1 : in_val1;
    assign w_in_val2 = w_in_hit2 ? w_in_cval2 : in_val2;
    assign w_in_tag1 = w_in_hit1 ? '0 : in_tag1;
    assign w_in_tag2 = w_in_hit2 ? '0 : in_tag2;

    assign in_ready = (r_count < c_DEPTH);
    assign w_enq    = in_valid && in_ready && !flush_all && !flush_younger;

    // Issue looks only at registered tags: a wakeup this edge issues next edge.
    assign w_head_rdy = r_busy[r_head] && (r_tag1[r_head] == '0) && (r_tag2[r_head] == '0);
    assign w_sw_block = (STORE_AT_HEAD != 0) && (r_opcode[r_head] == OPC_SW) &&
                        (r_rob_tag[r_head] != rob_head);
    assign w_issue    = w_head_rdy && !w_sw_block && (!r_out_valid || out_ready) &&
                        !flush_all && !flush_younger;

    assign w_out_young = is_younger(32'(r_out_rob_tag), 32'(flush_tag), 32'(rob_head), ROB_BITS);

    // Selective flush: mark younger entries and locate the oldest one in queue order.
    always_comb begin
        w_young     = '0;
        w_n_young   = '0;
        w_any_young = 1'b0;
        w_new_tail  = r_tail;
        w_idx       = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_young[i] = r_busy[i] &&
                         is_younger(32'(r_rob_tag[i]), 32'(flush_tag), 32'(rob_head), ROB_BITS);
            if (w_young[i]) begin
                w_n_young = w_n_young + c_CNT_W'(1);
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            w_idx = r_head + c_IDX_W'(j);
            if (!w_any_young && w_young[w_idx]) begin
                w_any_young = 1'b1;
                w_new_tail  = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst || flush_all) begin
                r_busy[i] <= 1'b0;
            end else if (flush_younger) begin
                if (w_young[i]) begin
                    r_busy[i] <= 1'b0;
                end
            end else if (w_enq && r_tail == c_IDX_W'(i)) begin
                r_busy[i] <= 1'b1;
            end else if (w_issue && r_head == c_IDX_W'(i)) begin
                r_busy[i] <= 1'b0;
            end

            if (w_enq && r_tail == c_IDX_W'(i)) begin
                r_opcode[i]  <= in_opcode;
                r_rd[i]      <= in_rd;
                r_rob_tag[i] <= in_rob_tag;
                r_tag1[i]    <= w_in_tag1;
                r_tag2[i]    <= w_in_tag2;
                r_val1[i]    <= w_in_val1;
                r_val2[i]    <= w_in_val2;
                r_imm[i]     <= in_imm;
                r_ea[i]      <= calc_ea(w_in_val1, in_imm);
            end else if (r_busy[i]) begin
                if (w_hit1[i]) begin
                    r_tag1[i] <= '0;
                    r_val1[i] <= w_cval1[i];
                    r_ea[i]   <= calc_ea(w_cval1[i], r_imm[i]);
                end
                if (w_hit2[i]) begin
                    r_tag2[i] <= '0;
                    r_val2[i] <= w_cval2[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_all) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_younger) begin
            if (w_any_young) begin
                r_tail <= w_new_tail;
            end
            r_count <= r_count - w_n_young;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + c_IDX_W'(1);
            end
            if (w_issue) begin
                r_head <= r_head + c_IDX_W'(1);
            end
            case ({w_enq, w_issue})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_rob_tag <= '0;
            r_out_rd      <= '0;
            r_out_opcode  <= '0;
            r_out_val1    <= '0;
            r_out_val2    <= '0;
            r_out_imm     <= '0;
            r_out_ea      <= '0;
        end else if (flush_all) begin
            r_out_valid <= 1'b0;
        end else if (flush_younger) begin
            if (w_out_young || out_ready) begin
                r_out_valid <= 1'b0;
            end
        end else if (w_issue) begin
            r_out_valid   <= 1'b1;
            r_out_rob_tag <= r_rob_tag[r_head];
            r_out_rd      <= r_rd[r_head];
            r_out_opcode  <= r_opcode[r_head];
            r_out_val1    <= r_val1[r_head];
            r_out_val2    <= r_val2[r_head];
            r_out_imm     <= r_imm[r_head];
            r_out_ea      <= r_ea[r_head];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_rob_tag = r_out_rob_tag;
    assign out_rd      = r_out_rd;
    assign out_opcode  = r_out_opcode;
    assign out_val1    = r_out_val1;
    assign out_val2    = r_out_val2;
    assign out_imm     = r_out_imm;
    assign out_ea      = r_out_ea;
    assign count       = r_count;
    assign head_idx    = r_head;
    assign tail_idx    = r_tail;

endmodule
`default_nettype wire

// File: tb/tb_ldst_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldst_queue
// Brief    : Scoreboard bench for ldst_queue (default parameters)
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldst_queue;
    import ldst_queue_pkg::*;

    localparam int c_DEPTH = 16;
    localparam int c_TW    = 5;
    localparam int c_NCDB  = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [c_TW-1:0]          in_rob_tag = '0, in_tag1 = '0, in_tag2 = '0;
    logic [4:0]               in_rd = '0;
    logic [11:0]              in_opcode = '0;
    logic [31:0]              in_val1 = '0, in_val2 = '0, in_imm = '0;
    logic [c_TW-1:0]          rob_head = '0;
    logic                     flush_all = 1'b0, flush_younger = 1'b0;
    logic [c_TW-1:0]          flush_tag = '0;
    logic [c_NCDB*c_TW-1:0]   cdb_tag = '0;
    logic [c_NCDB*32-1:0]     cdb_val = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [c_TW-1:0]          out_rob_tag;
    logic [4:0]               out_rd;
    logic [11:0]              out_opcode;
    logic [31:0]              out_val1, out_val2, out_imm, out_ea;
    logic [4:0]               count;
    logic [3:0]               head_idx, tail_idx;

    typedef struct packed {
        logic [c_TW-1:0] tag;
        logic [4:0]      rd;
        logic [11:0]     opc;
        logic [31:0]     v1;
        logic [31:0]     v2;
        logic [31:0]     imm;
        logic [31:0]     ea;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp, mon_act;
    int   checks = 0;
    int   errors = 0;

    ldst_queue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rob_tag(in_rob_tag), .in_tag1(in_tag1), .in_tag2(in_tag2),
        .in_rd(in_rd), .in_opcode(in_opcode), .in_val1(in_val1), .in_val2(in_val2),
        .in_imm(in_imm), .rob_head(rob_head), .flush_all(flush_all),
        .flush_younger(flush_younger), .flush_tag(flush_tag),
        .cdb_tag(cdb_tag), .cdb_val(cdb_val), .out_valid(out_valid), .out_ready(out_ready),
        .out_rob_tag(out_rob_tag), .out_rd(out_rd), .out_opcode(out_opcode),
        .out_val1(out_val1), .out_val2(out_val2), .out_imm(out_imm), .out_ea(out_ea),
        .count(count), .head_idx(head_idx), .tail_idx(tail_idx)
    );

    always #5 clk = ~clk;

    // Output handshake completes on the next rising edge; compare against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            mon_act = {out_rob_tag, out_rd, out_opcode, out_val1, out_val2, out_imm, out_ea};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got tag %0d, expected no output", out_rob_tag);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL out_entry: got %h, expected %h", mon_act, mon_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [c_TW-1:0] tag, input logic [11:0] opc,
                            input logic [31:0] v1, input logic [31:0] v2,
                            input logic [31:0] imm, input logic [4:0] rd);
        exp_t e;
        e.tag = tag; e.rd = rd; e.opc = opc; e.v1 = v1; e.v2 = v2; e.imm = imm;
        e.ea  = (v1 + imm) & 32'h0000_0FFF;
        sb.push_back(e);
    endtask

    task automatic dispatch(input logic [c_TW-1:0] tag, input logic [11:0] opc,
                            input logic [c_TW-1:0] t1, input logic [c_TW-1:0] t2,
                            input logic [31:0] v1, input logic [31:0] v2,
                            input logic [31:0] imm, input logic [4:0] rd);
        in_valid = 1'b1; in_rob_tag = tag; in_opcode = opc; in_tag1 = t1; in_tag2 = t2;
        in_val1 = v1; in_val2 = v2; in_imm = imm; in_rd = rd;
        step();
        in_valid = 1'b0;
    endtask

    task automatic set_cdb(input int k, input logic [c_TW-1:0] tag, input logic [31:0] val);
        cdb_tag[k*c_TW +: c_TW] = tag;
        cdb_val[k*32 +: 32]     = val;
    endtask

    task automatic clear_cdb();
        cdb_tag = '0;
        cdb_val = '0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL %s_drain: %0d entries still pending, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", count); end
        checks++; if (head_idx !== 4'd0 || tail_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got head %0d tail %0d required 0 0", head_idx, tail_idx); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if ({out_rob_tag, out_ea, out_val1} !== '0) begin errors++; $display("FAIL reset_out_fields: got tag %0d ea %h val1 %h required 0", out_rob_tag, out_ea, out_val1); end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        push_exp(5'd3, OPC_LW, 32'h100, 32'h0, 32'h4, 5'd1);
        dispatch(5'd3, OPC_LW, 5'd0, 5'd0, 32'h100, 32'h0, 32'h4, 5'd1);
        checks++; if (out_valid !== 1'b0 || count !== 5'd1) begin errors++; $display("FAIL lat_edge1: got valid %b count %0d required 0 1", out_valid, count); end
        step();
        checks++; if (out_valid !== 1'b1 || out_ea !== 32'h104) begin errors++; $display("FAIL lat_edge2: got valid %b ea %h required 1 104", out_valid, out_ea); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL lat_count: got %0d required 0", count); end
        wait_drain("latency");
    endtask

    task automatic test_dispatch_bypass();
        set_cdb(2, 5'd5, 32'h20);
        push_exp(5'd4, OPC_LW, 32'h20, 32'h0, 32'h8, 5'd2);
        dispatch(5'd4, OPC_LW, 5'd5, 5'd0, 32'hBAD, 32'h0, 32'h8, 5'd2);
        clear_cdb();
        step();
        checks++; if (out_valid !== 1'b1 || out_val1 !== 32'h20) begin errors++; $display("FAIL bypass_val1: got valid %b val1 %h required 1 20", out_valid, out_val1); end
        wait_drain("bypass");
    endtask

    task automatic test_wakeup();
        // tag1 wakeup: two ports match, the lower-numbered one must win
        push_exp(5'd6, OPC_LW, 32'h111, 32'h0, 32'h10, 5'd3);
        dispatch(5'd6, OPC_LW, 5'd9, 5'd0, 32'h0, 32'h0, 32'h10, 5'd3);
        step();
        checks++; if (out_valid !== 1'b0 || count !== 5'd1) begin errors++; $display("FAIL wake_wait: got valid %b count %0d required 0 1", out_valid, count); end
        set_cdb(3, 5'd9, 32'h555);
        set_cdb(0, 5'd9, 32'h111);
        step();
        clear_cdb();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wake_edge1: got valid %b required 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_ea !== 32'h121) begin errors++; $display("FAIL wake_edge2: got valid %b ea %h required 1 121", out_valid, out_ea); end
        wait_drain("wake1");
        // tag2 wakeup on a store that is already at the ROB head
        rob_head = 5'd8;
        push_exp(5'd8, OPC_SW, 32'h40, 32'hCAFEF00D, 32'h4, 5'd0);
        dispatch(5'd8, OPC_SW, 5'd0, 5'd11, 32'h40, 32'h0, 32'h4, 5'd0);
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wake2_wait: got valid %b required 0", out_valid); end
        set_cdb(1, 5'd11, 32'hCAFEF00D);
        step();
        clear_cdb();
        step();
        checks++; if (out_valid !== 1'b1 || out_val2 !== 32'hCAFEF00D) begin errors++; $display("FAIL wake2_val2: got valid %b val2 %h required 1 cafef00d", out_valid, out_val2); end
        wait_drain("wake2");
    endtask

    task automatic test_store_at_head();
        rob_head = 5'd6;
        push_exp(5'd7, OPC_SW, 32'h200, 32'h55, 32'h8, 5'd0);
        dispatch(5'd7, OPC_SW, 5'd0, 5'd0, 32'h200, 32'h55, 32'h8, 5'd0);
        step(); step();
        checks++; if (out_valid !== 1'b0 || count !== 5'd1) begin errors++; $display("FAIL sw_blocked: got valid %b count %0d required 0 1", out_valid, count); end
        rob_head = 5'd7;
        step();
        checks++; if (out_valid !== 1'b1 || out_opcode !== OPC_SW) begin errors++; $display("FAIL sw_issue: got valid %b opcode %h required 1 %h", out_valid, out_opcode, OPC_SW); end
        wait_drain("sw");
        rob_head = 5'd0;
    endtask

    task automatic test_fill_wrap();
        int accepted;
        logic [3:0] saved_tail;
        accepted  = 0;
        out_ready = 1'b0;
        for (int i = 0; i < c_DEPTH + 4; i++) begin
            if (!in_ready) break;
            push_exp(5'((i % 16) + 1), OPC_LW, 32'(i * 16), 32'(i), 32'(i), 5'(i));
            dispatch(5'((i % 16) + 1), OPC_LW, 5'd0, 5'd0, 32'(i * 16), 32'(i), 32'(i), 5'(i));
            accepted++;
        end
        checks++; if (accepted != c_DEPTH + 1) begin errors++; $display("FAIL fill_accepted: got %0d required %0d", accepted, c_DEPTH + 1); end
        checks++; if (count !== 5'd16 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got count %0d in_ready %b required 16 0", count, in_ready); end
        // Full: an offered entry must be refused even while the head issues this cycle.
        saved_tail = tail_idx;
        out_ready = 1'b1;
        dispatch(5'd16, OPC_LW, 5'd0, 5'd0, 32'hDEAD, 32'h0, 32'h0, 5'd31);
        checks++; if (count !== 5'd15 || tail_idx !== saved_tail) begin errors++; $display("FAIL full_ignore: got count %0d tail %0d required 15 %0d", count, tail_idx, saved_tail); end
        wait_drain("fill");
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL fill_empty: got count %0d required 0", count); end
    endtask

    task automatic test_flush_younger();
        logic [3:0] t0;
        out_ready = 1'b0;
        rob_head  = 5'd1;
        t0 = tail_idx;
        for (int i = 2; i <= 5; i++) begin
            dispatch(5'(i), OPC_LW, 5'd16, 5'd0, 32'h0, 32'h0, 32'h1, 5'(i));
        end
        checks++; if (count !== 5'd4) begin errors++; $display("FAIL fy_pre_count: got %0d required 4", count); end
        flush_younger = 1'b1;
        flush_tag     = 5'd3;
        step();
        flush_younger = 1'b0;
        checks++; if (count !== 5'd2) begin errors++; $display("FAIL fy_count: got %0d required 2", count); end
        checks++; if (tail_idx !== 4'(t0 + 4'd2)) begin errors++; $display("FAIL fy_tail: got %0d required %0d", tail_idx, 4'(t0 + 4'd2)); end
        push_exp(5'd2, OPC_LW, 32'h777, 32'h0, 32'h1, 5'd2);
        push_exp(5'd3, OPC_LW, 32'h777, 32'h0, 32'h1, 5'd3);
        set_cdb(0, 5'd16, 32'h777);
        out_ready = 1'b1;
        step();
        clear_cdb();
        wait_drain("flush_younger");
        rob_head = 5'd0;
    endtask

    task automatic test_flush_all();
        out_ready = 1'b0;
        dispatch(5'd9, OPC_LW, 5'd0, 5'd0, 32'h10, 32'h0, 32'h0, 5'd9);
        dispatch(5'd10, OPC_LW, 5'd0, 5'd0, 32'h20, 32'h0, 32'h0, 5'd10);
        checks++; if (out_valid !== 1'b1 || count !== 5'd1) begin errors++; $display("FAIL fa_stall: got valid %b count %0d required 1 1", out_valid, count); end
        flush_all = 1'b1;
        step();
        flush_all = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL fa_clear: got valid %b count %0d required 0 0", out_valid, count); end
        checks++; if (head_idx !== 4'd0 || tail_idx !== 4'd0) begin errors++; $display("FAIL fa_idx: got head %0d tail %0d required 0 0", head_idx, tail_idx); end
        out_ready = 1'b1;
        push_exp(5'd12, OPC_LW, 32'h300, 32'h0, 32'h30, 5'd12);
        dispatch(5'd12, OPC_LW, 5'd0, 5'd0, 32'h300, 32'h0, 32'h30, 5'd12);
        wait_drain("flush_all");
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL fa_final_count: got %0d required 0", count); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_dispatch_bypass();
        test_wakeup();
        test_store_at_head();
        test_fill_wrap();
        test_flush_younger();
        test_flush_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ldst_queue.md
# ldst_queue

Parametrised successor to the load/store buffer. An in-order circular queue that holds memory instructions between dispatch and the memory stage. It snoops N common data buses for base and store-data operands and computes the effective address. It releases the head entry through a registered valid/ready output stage, and it supports both full and selective (younger-than-tag) flush. It sits between the dispatch/address unit and the data-memory access unit of the out-of-order core.

## Interface
Parameters:
- DEPTH, 16: entry count, power of two ≥ 2
- ROB_BITS, 4: ROB has 2^ROB_BITS entries; tags are ROB_BITS+1 wide, 0 = "no dependency", valid tags 1..2^ROB_BITS
- N_CDB, 4: number of CDB snoop ports
- MEM_BITS, 12: low EA bits computed; upper EA bits are 0
- STORE_AT_HEAD, 1: 1 = a sw issues only when its ROB tag equals rob_head

Ports:
- clk  in  1  clock; every register updates on posedge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  dispatch strobe
- in_ready  out  1  count < DEPTH
- in_rob_tag, in_tag1, in_tag2  in  ROB_BITS+1  own tag, base-source tag, store-data-source tag
- in_rd  in  5; in_opcode  in  12; in_val1, in_val2, in_imm  in  32
- rob_head  in  ROB_BITS+1  tag at ROB head
- flush_all  in  1  discard everything
- flush_younger  in  1; flush_tag  in  ROB_BITS+1  discard entries younger than flush_tag
- cdb_tag  in  N_CDB*(ROB_BITS+1); cdb_val  in  N_CDB*32  flattened; port k is at slice k
- out_valid  out  1; out_ready  in  1
- out_rob_tag  out  ROB_BITS+1; out_rd  out  5; out_opcode  out  12; out_val1, out_val2, out_imm, out_ea  out  32
- count  out  $clog2(DEPTH)+1; head_idx, tail_idx  out  $clog2(DEPTH)

## Operation
- Entry fields: busy, opcode, rd, rob_tag, tag1/tag2, val1/val2, imm, ea. An entry is ready when tag1 == 0 and tag2 == 0.
- Enqueue: happens when in_valid && in_ready, into entry tail_idx; tail advances.
  - Each incoming nonzero tag is compared against all CDB ports in the same cycle. On a hit, the value is captured and the tag is written as 0.
  - ea[MEM_BITS-1:0] = val1 + imm, low bits only, using the bypassed val1.
  - in_valid while full is ignored and state is unchanged.
- Wakeup: for each busy entry, the lowest-numbered CDB port k with a nonzero tag matching tag1 captures val1 and recomputes ea; tag1 is cleared. tag2 is woken up the same way, independently.
- Issue: the head entry moves to the output register when all of these hold:
  - the head is busy and ready;
  - it is not a sw blocked by STORE_AT_HEAD (rob_tag != rob_head);
  - the output register is empty or out_ready is 1.
  - On a move, head advances and busy clears.
- Output register: holds its contents while out_valid && !out_ready. It is emptied by out_ready when no head entry is eligible.
- Age: age(t) = (t − rob_head) mod 2^ROB_BITS. An entry is younger than flush_tag when age(rob_tag) > age(flush_tag).
- Flush priority: rst > flush_all > flush_younger > normal.
  - flush_all clears every busy bit, head, tail, count and out_valid.
  - flush_younger clears younger entries. Tail becomes the index of the oldest younger entry, or is unchanged if none is younger. count is recomputed. out_valid is cleared if the output entry is younger. Enqueue and issue are suppressed that cycle.
- count = entries in the queue only, not the output register. Simultaneous enqueue and issue leaves count unchanged.

## Timing
- Reset values:
  - outputs: out_valid 0, all out_* fields 0, count 0, head_idx 0, tail_idx 0, in_ready 1;
  - internal: all entry busy bits 0.
- Latency:
  - enqueue with ready operands at edge N gives out_valid=1 after edge N+1;
  - a CDB hit at edge N on the head's last operand gives out_valid after edge N+1.
- in_ready is combinational from registered count. At full, in_ready stays 0 even if an issue occurs the same cycle.
- Wrap-around: head and tail wrap modulo DEPTH; full/empty is decided by count, never by index equality.
- Reset or flush mid-stall drops the output register regardless of out_ready.

## Structure
- Shared package: opcode constants (OPC_SW, OPC_LW), the tag-width function, and the age-compare function.
- One sub-module, ldst_cdb_snoop: a combinational N_CDB-port tag match that returns hit and value for one tag. Instantiate it per entry-operand and per incoming operand.

## Test plan
- After rst, dispatch lw tag 3, tag1=0, val1=0x100, imm=4, out_ready=1 → out_valid after 2 edges, out_ea=0x104, count returns to 0.
- Dispatch lw with tag1=5; drive cdb port 2 tag 5 val 0x20 on the dispatch edge → the entry is ready immediately and out_val1=0x20.
- sw tag 7 at head with rob_head=6 → it stays queued; set rob_head=7 → it issues next edge.
- Fill DEPTH entries with out_ready=0 → in_ready=0, count=DEPTH. An extra in_valid is ignored. Release → FIFO order is preserved across the wrap.
- rob_head=1, entries with tags 2,3,4,5; flush_younger with flush_tag=3 → tags 4,5 are removed, count=2, and tail points to the slot of tag 4.
- flush_all while the output register is stalled → next edge out_valid=0, count=0, head=tail=0.
